// File: rtl/pong_pkg.sv
// Shared pong geometry (pixels) and ball engine state type.
// Derived positions are expressed from the base geometry so they stay consistent.
package pong_pkg;

   localparam logic [10:0] FIELD_W       = 11'd783;
   localparam logic [10:0] FIELD_H       = 11'd480;
   localparam logic [10:0] NET_H         = 11'd391;
   localparam logic [10:0] BALL_SIZE     = 11'd8;
   localparam logic [10:0] PADDLE_LEN    = 11'd64;
   localparam logic [10:0] PADDLE_W      = 11'd8;
   localparam logic [10:0] PADDLE_L_EDGE = 11'd16;
   localparam logic [10:0] PADDLE_L_FACE = PADDLE_L_EDGE + PADDLE_W;
   localparam logic [10:0] PADDLE_R_FACE = 11'd760;

   // Ball left-edge positions at which the rules fire
   localparam logic [10:0] BALL_H_MAX    = FIELD_W - BALL_SIZE;
   localparam logic [10:0] BALL_V_MAX    = FIELD_H - BALL_SIZE;
   localparam logic [10:0] R_HIT_H       = PADDLE_R_FACE - BALL_SIZE;
   localparam logic [10:0] SERVE_H       = NET_H - BALL_SIZE / 11'd2;
   localparam logic [10:0] SERVE_V       = FIELD_H / 11'd2 - BALL_SIZE / 11'd2;

   typedef enum logic {
      SERVE,
      PLAY
   } ball_state_t;

   // True when an 8-px ball at row v overlaps a paddle whose top is at row top.
   function automatic logic v_overlap(input logic [10:0] v, input logic [10:0] top);
      return ((v + BALL_SIZE) > top) && (v < (top + PADDLE_LEN));
   endfunction

endpackage

// File: rtl/step_timer.sv
// Free-running prescaler: STROBE is high for one cycle every STEP_DIV clocks.
module step_timer #(
   parameter int unsigned STEP_DIV = 500000
) (
   input  logic CLOCK,
   input  logic RESET,
   output logic STROBE
);

   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign STROBE = (cnt_q == LAST);

   always_comb begin
      cnt_d = STROBE ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ball.sv
// Pong ball motion engine: serve delay, one-pixel steps, wall/paddle bounces,
// miss detection with one-cycle score pulses.
module ball
   import pong_pkg::*;
#(
   parameter int unsigned STEP_DIV    = 500000,
   parameter int unsigned SERVE_STEPS = 120
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [7:0]  PADDLE_L,
   input  logic [7:0]  PADDLE_R,
   output logic [10:0] BALL_H,
   output logic [10:0] BALL_V,
   output logic        SCORE_L,
   output logic        SCORE_R,
   output logic        SERVING
);

   localparam int unsigned SW = (SERVE_STEPS > 1) ? $clog2(SERVE_STEPS) : 1;
   localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_STEPS - 1);

   ball_state_t   state_q, state_d;
   logic [10:0]   h_q, h_d, v_q, v_d;
   logic          dx_q, dx_d, dy_q, dy_d;   // 0 = +1, 1 = -1
   logic [SW-1:0] cnt_q, cnt_d;
   logic          score_l_q, score_l_d, score_r_q, score_r_d;
   logic          serving_q, serving_d;
   logic          strobe;
   logic [10:0]   pl, pr;

   step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
      .CLOCK  (CLOCK),
      .RESET  (RESET),
      .STROBE (strobe)
   );

   assign pl = {2'b00, PADDLE_L, 1'b0};
   assign pr = {2'b00, PADDLE_R, 1'b0};

   always_comb begin
      state_d   = state_q;
      h_d       = h_q;
      v_d       = v_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      cnt_d     = cnt_q;
      score_l_d = 1'b0;
      score_r_d = 1'b0;
      if (strobe) begin
         unique case (state_q)
            SERVE: begin
               if (cnt_q == SERVE_LAST) begin
                  cnt_d   = '0;
                  state_d = PLAY;
               end else begin
                  cnt_d = cnt_q + SW'(1);
               end
            end
            PLAY: begin
               if (!dx_q && h_q == BALL_H_MAX) begin
                  score_l_d = 1'b1;
                  state_d   = SERVE;
                  h_d       = SERVE_H;
                  v_d       = SERVE_V;
                  dx_d      = 1'b0;
                  dy_d      = ~dy_q;
               end else if (dx_q && h_q == '0) begin
                  score_r_d = 1'b1;
                  state_d   = SERVE;
                  h_d       = SERVE_H;
                  v_d       = SERVE_V;
                  dx_d      = 1'b1;
                  dy_d      = ~dy_q;
               end else begin
                  // Horizontal and vertical reversals are independent so corner hits apply both
                  if (!dx_q && h_q == R_HIT_H && v_overlap(v_q, pr)) begin
                     dx_d = 1'b1;
                     h_d  = R_HIT_H - 11'd1;
                  end else if (dx_q && h_q == PADDLE_L_FACE && v_overlap(v_q, pl)) begin
                     dx_d = 1'b0;
                     h_d  = PADDLE_L_FACE + 11'd1;
                  end else begin
                     h_d = dx_q ? h_q - 11'd1 : h_q + 11'd1;
                  end
                  if (!dy_q && v_q == BALL_V_MAX) begin
                     dy_d = 1'b1;
                     v_d  = BALL_V_MAX - 11'd1;
                  end else if (dy_q && v_q == '0) begin
                     dy_d = 1'b0;
                     v_d  = 11'd1;
                  end else begin
                     v_d = dy_q ? v_q - 11'd1 : v_q + 11'd1;
                  end
               end
            end
            default: ;
         endcase
      end
      serving_d = (state_d == SERVE);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q   <= SERVE;
         h_q       <= SERVE_H;
         v_q       <= SERVE_V;
         dx_q      <= 1'b1;
         dy_q      <= 1'b0;
         cnt_q     <= '0;
         score_l_q <= 1'b0;
         score_r_q <= 1'b0;
         serving_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         h_q       <= h_d;
         v_q       <= v_d;
         dx_q      <= dx_d;
         dy_q      <= dy_d;
         cnt_q     <= cnt_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         serving_q <= serving_d;
      end
   end

   assign BALL_H  = h_q;
   assign BALL_V  = v_q;
   assign SCORE_L = score_l_q;
   assign SCORE_R = score_r_q;
   assign SERVING = serving_q;

endmodule

// File: tb/tb_ball.sv
// Self-checking bench for ball: step-level reference model plus reset table
// and directed wall, paddle-edge, miss and reset-during-miss sequences.
module tb_ball;

   localparam int DIV = 2;
   localparam int SS  = 3;

   localparam int K_RDEC  = 0;
   localparam int K_LMISS = 1;
   localparam int K_RMISS = 2;
   localparam int K_BOT   = 3;
   localparam int K_TOP   = 4;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [7:0]  PADDLE_L = 8'd0;
   logic [7:0]  PADDLE_R = 8'd0;
   logic [10:0] BALL_H, BALL_V;
   logic        SCORE_L, SCORE_R, SERVING;

   ball #(.STEP_DIV(DIV), .SERVE_STEPS(SS)) dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .PADDLE_L (PADDLE_L),
      .PADDLE_R (PADDLE_R),
      .BALL_H   (BALL_H),
      .BALL_V   (BALL_V),
      .SCORE_L  (SCORE_L),
      .SCORE_R  (SCORE_R),
      .SERVING  (SERVING)
   );

   always #5 CLOCK = ~CLOCK;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: ball kinematics in signed steps (+1/-1 directions)
   typedef struct {
      int pc, cnt, h, v, dx, dy;
      bit play, sl, sr;
   } m_t;

   m_t m;
   bit m_valid = 1'b0;

   function automatic bit overlaps(input int v, input int p);
      return (v + 8 > p) && (v < p + 64);
   endfunction

   function automatic m_t reset_state();
      m_t r;
      r.pc = 0; r.cnt = 0; r.h = 387; r.v = 236; r.dx = -1; r.dy = 1;
      r.play = 1'b0; r.sl = 1'b0; r.sr = 1'b0;
      return r;
   endfunction

   function automatic m_t step(input m_t s, input int pl, input int pr);
      m_t n = s;
      bit stb;
      stb  = (n.pc == DIV - 1);
      n.pc = stb ? 0 : n.pc + 1;
      n.sl = 1'b0;
      n.sr = 1'b0;
      if (!stb) return n;
      if (!n.play) begin
         n.cnt = n.cnt + 1;
         if (n.cnt == SS) begin
            n.cnt  = 0;
            n.play = 1'b1;
         end
      end else if (n.dx > 0 && n.h == 775) begin
         n.sl = 1'b1; n.play = 1'b0; n.h = 387; n.v = 236; n.dx = 1; n.dy = -n.dy;
      end else if (n.dx < 0 && n.h == 0) begin
         n.sr = 1'b1; n.play = 1'b0; n.h = 387; n.v = 236; n.dx = -1; n.dy = -n.dy;
      end else begin
         if (n.dx > 0 && n.h == 752 && overlaps(n.v, pr)) n.dx = -1;
         else if (n.dx < 0 && n.h == 24 && overlaps(n.v, pl)) n.dx = 1;
         if ((n.dy > 0 && n.v == 472) || (n.dy < 0 && n.v == 0)) n.dy = -n.dy;
         n.h = n.h + n.dx;
         n.v = n.v + n.dy;
      end
      return n;
   endfunction

   always @(posedge CLOCK) begin
      if (RESET) begin
         m       <= reset_state();
         m_valid <= 1'b1;
      end else begin
         m <= step(m, 2 * int'(PADDLE_L), 2 * int'(PADDLE_R));
      end
   end

   always @(negedge CLOCK) begin
      if (m_valid) begin
         n_checks++;
         if (BALL_H !== 11'(m.h) || BALL_V !== 11'(m.v) || SCORE_L !== m.sl ||
             SCORE_R !== m.sr || SERVING !== !m.play) begin
            n_errors++;
            $display("FAIL track t=%0t: got H=%0d V=%0d SL=%b SR=%b SRV=%b, expected H=%0d V=%0d SL=%0d SR=%0d SRV=%0d",
                     $time, BALL_H, BALL_V, SCORE_L, SCORE_R, SERVING,
                     m.h, m.v, m.sl, m.sr, !m.play);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] pl, pr;
      int h, v, serving, sl, sr;
   } vec_t;

   vec_t tbl[6];

   // Called at a negedge; the next edge is the reset edge.
   task automatic apply_reset_table();
      RESET = 1'b1;
      @(negedge CLOCK);
      RESET = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (i > 0) begin
            PADDLE_L = tbl[i].pl;
            PADDLE_R = tbl[i].pr;
            repeat (2) @(negedge CLOCK);
         end
         chk($sformatf("rst_h[%0d]", i), int'(BALL_H), tbl[i].h);
         chk($sformatf("rst_v[%0d]", i), int'(BALL_V), tbl[i].v);
         chk($sformatf("rst_serving[%0d]", i), int'(SERVING), tbl[i].serving);
         chk($sformatf("rst_score_l[%0d]", i), int'(SCORE_L), tbl[i].sl);
         chk($sformatf("rst_score_r[%0d]", i), int'(SCORE_R), tbl[i].sr);
      end
   endtask

   function automatic logic [7:0] hit_pad(input int v);
      return (v >= 20) ? 8'((v - 20) / 2) : 8'd0;
   endfunction

   function automatic logic [7:0] miss_pad(input int v);
      return (v < 240) ? 8'd240 : 8'd0;
   endfunction

   // Steers paddles and returns at the negedge before the strobe where the
   // requested situation is decided.
   task automatic wait_for(input int kind, output bit ok);
      bit hit;
      ok = 1'b0;
      for (int c = 0; c < 8000; c++) begin
         @(negedge CLOCK);
         if (m.pc == DIV - 1) begin
            PADDLE_L = (kind == K_LMISS) ? miss_pad(m.v) : hit_pad(m.v);
            PADDLE_R = (kind == K_RMISS) ? miss_pad(m.v) : hit_pad(m.v);
            case (kind)
               K_RDEC:  hit = (m.dx == 1 && m.h == 752);
               K_LMISS: hit = (m.dx == -1 && m.h == 0);
               K_RMISS: hit = (m.dx == 1 && m.h == 775);
               K_BOT:   hit = (m.dy == 1 && m.v == 472);
               default: hit = (m.dy == -1 && m.v == 0);
            endcase
            if (m.play && hit) begin
               ok = 1'b1;
               break;
            end
         end else begin
            PADDLE_L = 8'($urandom);
            PADDLE_R = 8'($urandom);
         end
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL timeout_kind%0d: got no event expected event within 8000 cycles", kind);
      end
   endtask

   // Called at the negedge before a miss strobe.
   task automatic check_miss(input bit right, input int dy_b);
      @(negedge CLOCK);
      chk("miss_score_l", int'(SCORE_L), right ? 1 : 0);
      chk("miss_score_r", int'(SCORE_R), right ? 0 : 1);
      chk("miss_serving", int'(SERVING), 1);
      chk("miss_h", int'(BALL_H), 387);
      chk("miss_v", int'(BALL_V), 236);
      @(negedge CLOCK);
      chk("pulse_end_l", int'(SCORE_L), 0);
      chk("pulse_end_r", int'(SCORE_R), 0);
      repeat (4) @(negedge CLOCK);
      chk("serve_hold", int'(SERVING), 1);
      @(negedge CLOCK);
      chk("serve_end", int'(SERVING), 0);
      chk("serve_end_h", int'(BALL_H), 387);
      repeat (2) @(negedge CLOCK);
      chk("serve_first_h", int'(BALL_H), right ? 388 : 386);
      chk("serve_first_v", int'(BALL_V), 236 - dy_b);
   endtask

   initial begin
      bit ok;
      int v, pr, dy_b;
      bit exp_hit;

      tbl[0] = '{pl: 8'($urandom), pr: 8'($urandom), h: 387, v: 236, serving: 1, sl: 0, sr: 0};
      tbl[1] = '{pl: 8'($urandom), pr: 8'($urandom), h: 387, v: 236, serving: 1, sl: 0, sr: 0};
      tbl[2] = '{pl: 8'($urandom), pr: 8'($urandom), h: 387, v: 236, serving: 1, sl: 0, sr: 0};
      tbl[3] = '{pl: 8'($urandom), pr: 8'($urandom), h: 387, v: 236, serving: 0, sl: 0, sr: 0};
      tbl[4] = '{pl: 8'($urandom), pr: 8'($urandom), h: 386, v: 237, serving: 0, sl: 0, sr: 0};
      tbl[5] = '{pl: 8'($urandom), pr: 8'($urandom), h: 385, v: 238, serving: 0, sl: 0, sr: 0};

      @(negedge CLOCK);
      apply_reset_table();

      repeat (4000) begin
         @(negedge CLOCK);
         PADDLE_L = 8'($urandom);
         PADDLE_R = 8'($urandom);
      end

      wait_for(K_BOT, ok);
      if (ok) begin
         @(negedge CLOCK);
         chk("bottom_v", int'(BALL_V), 471);
      end
      wait_for(K_TOP, ok);
      if (ok) begin
         @(negedge CLOCK);
         chk("top_v", int'(BALL_V), 1);
      end

      // Right paddle one pixel inside / outside both overlap edges
      for (int cls = 0; cls < 4; cls++) begin
         wait_for(K_RDEC, ok);
         if (ok) begin
            v = m.v;
            dy_b = m.dy;
            case (cls)
               0:       pr = v + 7;
               1:       pr = v + 9;
               2:       pr = v - 63;
               default: pr = v - 65;
            endcase
            if (pr < 0) pr = 0;
            if (pr > 510) pr = 510;
            pr = pr & ~1;
            PADDLE_R = 8'(pr / 2);
            exp_hit = overlaps(v, pr);
            @(negedge CLOCK);
            chk($sformatf("rpad_h_cls%0d", cls), int'(BALL_H), exp_hit ? 751 : 753);
            chk($sformatf("rpad_score_cls%0d", cls), int'(SCORE_L), 0);
            if (!exp_hit) begin
               wait_for(K_RMISS, ok);
               if (ok) begin
                  dy_b = m.dy;
                  check_miss(1'b1, dy_b);
               end
            end
         end
      end

      wait_for(K_LMISS, ok);
      if (ok) begin
         PADDLE_L = (m.v >= 64) ? 8'd0 : 8'd200;
         dy_b = m.dy;
         check_miss(1'b0, dy_b);
      end

      // Reset lands on the very strobe that would have scored
      wait_for(K_RMISS, ok);
      if (ok) apply_reset_table();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
